// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one WIDTH x WIDTH product every WIDTH+2 cycles.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port and two's-complement support.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mreg;
  logic [CW-1:0]    cnt;
  logic             mode;

  logic             mode_in;
  logic             last;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   sum;

`ifdef SEQ_MULT_SIGNED_EN
  assign mode_in = signed_mode;
`else
  assign mode_in = 1'b0;
`endif

  assign last      = (cnt == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Extension bit is the sign only in signed mode; mode is constant 0 in the unsigned build.
  assign acc_ext   = {mode & acc[WIDTH-1], acc};
  assign mcand_ext = {mode & mcand[WIDTH-1], mcand};

  always_comb begin
    sum = acc_ext;
    if (mreg[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
      // The multiplier's MSB carries weight -2^(WIDTH-1) in two's complement.
      if (last && mode)
        sum = acc_ext - mcand_ext;
      else
        sum = acc_ext + mcand_ext;
`else
      sum = acc_ext + mcand_ext;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mreg  <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= x;
            mreg  <= y;
            acc   <= '0;
            cnt   <= '0;
            mode  <= mode_in;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= sum[WIDTH:1];
          mreg <= {sum[0], mreg[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (last) begin
            p     <= {sum[WIDTH:1], sum[0], mreg[WIDTH-1:1]};
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
